// File: rtl/lz77_decoder_stream.sv
// lz77_decoder_stream: handshaked LZ77 token decoder (copy run from history, then one literal)
//
// Ports:
//   i_clk, i_reset          rising-edge clock, synchronous active-high reset
//   i_tok_valid/o_tok_ready token handshake for i_code_pos, i_code_len, i_chardata
//   o_out_valid/i_out_ready output handshake for o_char_nxt (registered)
//   o_encode                constant 0 (decoder mode flag)
//   o_finish                sticky, set once the terminator character has been accepted
//   o_pos_err               sticky copy-position error
//
// Build option: define LZ77_DEC_POSCHK_EN to flag tokens whose copy position
// reaches beyond the characters decoded so far; otherwise o_pos_err is tied 0.
module lz77_decoder_stream #(
    parameter int              DATA_W    = 8,
    parameter int              DEPTH     = 9,
    parameter int              POS_W     = 4,
    parameter int              LEN_W     = 3,
    parameter logic [DATA_W-1:0] TERM_CHAR = 8'h24
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tok_valid,
    output logic              o_tok_ready,
    input  logic [POS_W-1:0]  i_code_pos,
    input  logic [LEN_W-1:0]  i_code_len,
    input  logic [DATA_W-1:0] i_chardata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_char_nxt,
    output logic              o_encode,
    output logic              o_finish,
    output logic              o_pos_err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_hist [DEPTH];
    logic [POS_W-1:0]  r_pos;
    logic [LEN_W-1:0]  r_len, r_cnt;
    logic [DATA_W-1:0] r_chr, r_char;
    logic              r_out_valid, r_finish;
    logic              w_adv, w_acc, w_prod, w_is_copy;
    logic [DATA_W-1:0] w_copy, w_char;
    always_comb begin
        w_adv       = !r_out_valid || i_out_ready;
        o_tok_ready = !i_reset && r_state == S_IDLE && w_adv;
        w_acc       = i_tok_valid && o_tok_ready;
        w_prod      = r_state == S_RUN && w_adv;
        w_is_copy   = r_cnt < r_len;
        // Positions outside the history read as zero.
        w_copy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(r_pos) == i) w_copy = r_hist[i];
        w_char      = w_is_copy ? w_copy : r_chr;
        w_state_nxt = r_state;
        if (w_acc) w_state_nxt = S_RUN;
        if (w_prod) w_state_nxt = (w_char == TERM_CHAR) ? S_DONE : (w_is_copy ? S_RUN : S_IDLE);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_pos       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_chr       <= '0;
            r_char      <= '0;
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_pos <= i_code_pos;
                r_len <= i_code_len;
                r_chr <= i_chardata;
                r_cnt <= '0;
            end
            // Each produced char is also pushed into history, so overlapping
            // copies read the chars this same run just emitted.
            if (w_prod) begin
                r_char      <= w_char;
                r_out_valid <= 1'b1;
                r_hist[0]   <= w_char;
                for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
                if (w_is_copy) r_cnt <= r_cnt + 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            // In DONE the only pending output is the terminator itself.
            if (r_state == S_DONE && r_out_valid && i_out_ready) r_finish <= 1'b1;
        end
    end
`ifdef LZ77_DEC_POSCHK_EN
    localparam int FILL_W = $clog2(DEPTH + 1);
    logic [FILL_W-1:0] r_fill;
    logic              r_pos_err;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fill    <= '0;
            r_pos_err <= 1'b0;
        end else begin
            if (w_prod && int'(r_fill) < DEPTH) r_fill <= r_fill + 1'b1;
            if (w_acc && i_code_len != '0 && int'(i_code_pos) >= int'(r_fill)) r_pos_err <= 1'b1;
        end
    end
    assign o_pos_err = r_pos_err;
`else
    assign o_pos_err = 1'b0;
`endif
    assign o_out_valid = r_out_valid;
    assign o_char_nxt  = r_char;
    assign o_encode    = 1'b0;
    assign o_finish    = r_finish;
endmodule

// File: tb/tb_lz77_decoder_stream.sv
// tb_lz77_decoder_stream: directed bench for lz77_decoder_stream (default and DEPTH=32 instances)
module tb_lz77_decoder_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_tests = 0, n_fail = 0, cyc = 0;
    logic       a_reset, a_tok_valid, a_tok_ready, a_ov, a_or, a_enc, a_fin, a_perr;
    logic [3:0] a_pos;
    logic [2:0] a_len;
    logic [7:0] a_chr, a_char;
    logic       b_reset, b_tok_valid, b_tok_ready, b_ov, b_or, b_enc, b_fin, b_perr;
    logic [4:0] b_pos;
    logic [3:0] b_len;
    logic [7:0] b_chr, b_char;
    logic [7:0] qa[$], qb[$];
    int         qa_cyc[$];
    logic [7:0] held;
    logic       exp_perr;
    lz77_decoder_stream u_a (
        .i_clk(clk), .i_reset(a_reset), .i_tok_valid(a_tok_valid), .o_tok_ready(a_tok_ready),
        .i_code_pos(a_pos), .i_code_len(a_len), .i_chardata(a_chr), .o_out_valid(a_ov),
        .i_out_ready(a_or), .o_char_nxt(a_char), .o_encode(a_enc), .o_finish(a_fin), .o_pos_err(a_perr)
    );
    lz77_decoder_stream #(.DEPTH(32), .POS_W(5), .LEN_W(4)) u_b (
        .i_clk(clk), .i_reset(b_reset), .i_tok_valid(b_tok_valid), .o_tok_ready(b_tok_ready),
        .i_code_pos(b_pos), .i_code_len(b_len), .i_chardata(b_chr), .o_out_valid(b_ov),
        .i_out_ready(b_or), .o_char_nxt(b_char), .o_encode(b_enc), .o_finish(b_fin), .o_pos_err(b_perr)
    );
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (a_ov && a_or) begin
            qa.push_back(a_char);
            qa_cyc.push_back(cyc);
        end
        if (b_ov && b_or) qb.push_back(b_char);
    end
    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task send_a(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        logic ok;
        ok = 1'b0;
        a_pos = p; a_len = l; a_chr = c; a_tok_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (a_tok_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        a_tok_valid = 1'b0;
        check("send_a_accept", 32'(ok), 1);
    endtask
    task send_b(input logic [4:0] p, input logic [3:0] l, input logic [7:0] c);
        logic ok;
        ok = 1'b0;
        b_pos = p; b_len = l; b_chr = c; b_tok_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (b_tok_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        b_tok_valid = 1'b0;
        if (!ok) check("send_b_accept", 32'(ok), 1);
    endtask
    task reset_a();
        a_reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        a_reset = 1'b0;
        qa.delete();
        qa_cyc.delete();
    endtask
    task wait_qa(input int n);
        for (int i = 0; i < 200 && qa.size() < n; i++) begin @(posedge clk); #1; end
        repeat (4) begin @(posedge clk); #1; end
    endtask
    task chk_str(input string tag, input string s);
        check({tag, "_count"}, qa.size(), s.len());
        for (int i = 0; i < s.len() && i < qa.size(); i++) check(tag, qa[i], 32'(s[i]));
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        a_reset = 1'b1; a_tok_valid = 1'b0; a_pos = '0; a_len = '0; a_chr = '0; a_or = 1'b1;
        b_reset = 1'b1; b_tok_valid = 1'b0; b_pos = '0; b_len = '0; b_chr = '0; b_or = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tok_ready", a_tok_ready, 0);
        check("rst_out_valid", a_ov, 0);
        check("rst_char", a_char, 0);
        check("rst_encode", a_enc, 0);
        check("rst_finish", a_fin, 0);
        check("rst_pos_err", a_perr, 0);
        @(posedge clk); #1;
        a_reset = 1'b0; b_reset = 1'b0;
        qa.delete(); qa_cyc.delete(); qb.delete();
        // basic decode with terminator
        send_a(0, 0, "a");
        send_a(0, 0, "b");
        send_a(1, 3, "$");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ov && a_char == 8'h24) break;
        end
        check("t1_fin_before", a_fin, 0);
        @(negedge clk);
        check("t1_fin_after", a_fin, 1);
        check("t1_tok_ready_done", a_tok_ready, 0);
        check("t1_ov_drop", a_ov, 0);
        @(posedge clk); #1;
        a_tok_valid = 1'b1;
        wait_qa(6);
        a_tok_valid = 1'b0;
        chk_str("t1", "ababa$");
        check("t1_fin_sticky", a_fin, 1);
        check("t1_encode", a_enc, 0);
        // overlapping run, one char per cycle
        reset_a();
        send_a(0, 0, "x");
        send_a(0, 5, "y");
        wait_qa(7);
        chk_str("t2", "xxxxxxy");
        check("t2_span", qa_cyc.size() == 7 ? 32'(qa_cyc[6] - qa_cyc[1]) : 32'hffff_ffff, 5);
        // backpressure mid-run
        reset_a();
        send_a(0, 0, "a");
        send_a(0, 0, "b");
        send_a(1, 6, "c");
        repeat (2) begin @(posedge clk); #1; end
        a_or = 1'b0;
        @(negedge clk);
        held = a_char;
        check("t3_ov_hold", a_ov, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_char_stable", a_char, held);
            check("t3_ov_stable", a_ov, 1);
        end
        @(posedge clk); #1;
        a_or = 1'b1;
        wait_qa(9);
        chk_str("t3", "ababababc");
        // reset during a run
        reset_a();
        send_a(0, 0, "m");
        send_a(0, 7, "n");
        repeat (2) begin @(posedge clk); #1; end
        a_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_tok_ready", a_tok_ready, 0);
        check("t4_ov", a_ov, 0);
        check("t4_char", a_char, 0);
        check("t4_fin", a_fin, 0);
        check("t4_perr", a_perr, 0);
        @(posedge clk); #1;
        a_reset = 1'b0;
        qa.delete(); qa_cyc.delete();
        send_a(0, 0, "q");
        wait_qa(1);
        chk_str("t4_q", "q");
        send_a(3, 1, "r");
        wait_qa(3);
        check("t4_count", qa.size(), 3);
        check("t4_hist_zero", qa.size() == 3 ? qa[1] : 8'hff, 0);
        check("t4_r", qa.size() == 3 ? qa[2] : 8'hff, "r");
        // copy beyond decoded history
        reset_a();
        send_a(0, 0, "a");
        send_a(0, 0, "b");
        send_a(5, 2, "z");
        wait_qa(5);
        check("t5_count", qa.size(), 5);
        check("t5_c0", qa.size() == 5 ? qa[2] : 8'hff, 0);
        check("t5_c1", qa.size() == 5 ? qa[3] : 8'hff, 0);
        check("t5_lit", qa.size() == 5 ? qa[4] : 8'hff, "z");
`ifdef LZ77_DEC_POSCHK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        check("t5_pos_err", a_perr, exp_perr);
        // deep history instance: 31 literals then a 15-long copy from the oldest entry
        for (int i = 0; i < 31; i++) send_b(0, 0, 8'(i + 1));
        send_b(30, 15, "$");
        for (int i = 0; i < 200 && qb.size() < 47; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        check("t6_count", qb.size(), 47);
        for (int i = 0; i < 15; i++) check("t6_copy", qb.size() == 47 ? qb[31 + i] : 8'hff, 8'(i + 1));
        check("t6_term", qb.size() == 47 ? qb[46] : 8'hff, "$");
        check("t6_fin", b_fin, 1);
        check("t6_tok_ready", b_tok_ready, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
